// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter and the cache controllers it serves.
// Holds the arbiter state encodings and the line/word geometry.
package mem_arbiter_pkg;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_GRANT = 1'b1;

    localparam int LINE_BYTES    = 16;
    localparam int WORD_BYTES    = 4;
    localparam int BURST_LEN_DEF = LINE_BYTES / WORD_BYTES;
    localparam int WORD_OFF_W    = $clog2(WORD_BYTES);
    localparam int LINE_OFF_W    = $clog2(LINE_BYTES);

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or cyclically above ptr.
// Kept standalone so other bus arbiters can reuse it.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan from the farthest candidate down so the nearest one to ptr wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-wide memory port among several cache
// controllers; the grant is locked for a whole line burst or until the owner aborts.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int IDW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [DATA_W-1:0]             req_rdata,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ready,
    output logic                          grant_valid,
    output logic [IDW-1:0]                grant_id
);

    localparam int CNTW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [0:0]      state;
    logic [IDW-1:0]  owner;
    logic [IDW-1:0]  rr_ptr;
    logic [CNTW-1:0] beat_cnt;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic            in_grant;
    logic            owner_valid;
    logic            beat;
    logic            last_beat;
    logic            release_now;

    function automatic logic [IDW-1:0] next_port(input logic [IDW-1:0] p);
        return (int'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
    endfunction

    // The picker only feeds registers, so non-owner requests never reach mem_* combinationally.
    rr_picker #(
        .N  (NUM_PORTS),
        .IW (IDW)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign in_grant    = (state == ARB_GRANT);
    assign owner_valid = req_valid[owner];
    assign mem_req     = in_grant & owner_valid;
    assign beat        = mem_req & mem_ready;
    assign last_beat   = (beat_cnt == CNTW'(BURST_LEN - 1));
    assign release_now = in_grant & (~owner_valid | (beat & last_beat));

    assign grant_valid = in_grant;
    assign grant_id    = in_grant ? owner : '0;
    assign req_rdata   = mem_rdata;
    assign mem_we      = in_grant & req_we[owner];
    assign mem_addr    = in_grant ? req_addr[int'(owner)*ADDR_W +: ADDR_W] : '0;
    assign mem_wdata   = in_grant ? req_wdata[int'(owner)*DATA_W +: DATA_W] : '0;

    always_comb begin
        req_ready = '0;
        if (beat) begin
            req_ready[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ARB_GRANT;
                    end
                end
                default: begin
                    // A dropped request releases immediately; the partial burst is abandoned.
                    if (release_now) begin
                        state    <= ARB_IDLE;
                        rr_ptr   <= next_port(owner);
                        beat_cnt <= '0;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
